// File: rtl/pmem_responder.sv
// Timed valid/ready memory responder for the core load/store port.
// One outstanding request; response after LATENCY extra cycles, with byte-masked writes.
module pmem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  if (LATENCY > 15) begin : g_bad_latency
    $fatal(1, "pmem_responder: LATENCY must be 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "pmem_responder: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          commit;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wmask;
  logic [29:0]   word_off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  // With LATENCY=0 the access commits on the accept edge, so it uses the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
  end

  // Range check precedes the modulo so aliased addresses never reach the array.
  assign word_off         = acc_addr[31:2] - ADDR_BASE[31:2];
  assign in_range         = ({2'b00, word_off} < 32'(DEPTH));
  assign idx              = word_off[AW-1:0];
  assign unused_addr_bits = ^acc_addr[1:0];

  assign commit = ((state_q == S_IDLE) && req_valid && (LATENCY == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (!acc_we && in_range) ? mem[idx] : '0;
      err_d   = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && acc_we && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_wmask[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: four instances (LATENCY 0/1/3/15) driven with directed
// steps and random write/read pairs checked against an array reference model.
module tb_pmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          NI    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wmask [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int total = 0;
  int bad   = 0;

  logic [31:0] model [NI][16];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 15;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pmem_responder #(
      .ADDR_BASE(BASE),
      .DEPTH(DEPTH),
      .LATENCY((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15)
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pool_addr(input int i);
    return (i == 15) ? BASE + 32'(4 * (DEPTH - 1)) : BASE + 32'(4 * i * 37);
  endfunction

  // One full transaction: accept, latency count, optional backpressure, handshake.
  task automatic xact(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                      input logic [31:0] exp_rd, input bit exp_err);
    int n;
    logic [31:0] rd0;
    logic e0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_wmask[k] = 4'($urandom);
    n = 0;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(k)));
    if (n >= 40) return;
    rd0 = rsp_rdata[k];
    e0  = rsp_err[k];
    chk("rdata", rd0, exp_rd);
    chk("err", 32'(e0), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_rdata", rsp_rdata[k], rd0);
      chk("hold_err", 32'(rsp_err[k]), 32'(e0));
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[k]), 32'd0);
    chk("ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [3:0]  m;
    int          i;
    bit          oob;

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_wmask[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_err", 32'(rsp_err[k]), 32'd0);
    end

    // Directed steps on the LATENCY=1 instance.
    xact(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    xact(1, 1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, 0, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 4, 32'hDEAD_AAEF, 1'b0);
    xact(1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 0, 32'hDEAD_AAEF, 1'b0);
    xact(1, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    xact(1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 0, 32'h0, 1'b1);
    xact(1, 1'b1, BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0, 4'hF, 1, 32'h0, 1'b1);
    xact(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h1122_3344, 1'b0);

    // Reset while a write sits in WAIT on the LATENCY=3 instance.
    xact(2, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h8000_0020;
    req_wdata[2] = 32'h1234_5678; req_wmask[2] = 4'hF;
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("rst_mid_no_valid", 32'(rsp_valid[2]), 32'd0);
      chk("rst_mid_ready", 32'(req_ready[2]), 32'd1);
      @(negedge clk);
    end
    xact(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Random write/read pairs against the reference model on every instance.
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 16; p++) begin
        d = $urandom;
        model[k][p] = d;
        xact(k, 1'b1, pool_addr(p), d, 4'hF, 0, 32'h0, 1'b0);
      end
      for (int t = 0; t < 100; t++) begin
        i   = $urandom_range(0, 15);
        d   = $urandom;
        m   = 4'($urandom_range(0, 15));
        oob = ($urandom_range(0, 7) == 0);
        if (oob) a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63))
                                                 : BASE - 32'(4 * $urandom_range(1, 64));
        else begin
          a = pool_addr(i) + 32'($urandom_range(0, 3));
          model[k][i] = merge(model[k][i], d, m);
        end
        xact(k, 1'b1, a, d, m, $urandom_range(0, 2), 32'h0, oob);
        i = $urandom_range(0, 15);
        xact(k, 1'b0, pool_addr(i) + 32'($urandom_range(0, 3)), $urandom, 4'($urandom),
             $urandom_range(0, 2), model[k][i], 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
